// File: rtl/sr_request_conditioner.sv
// sr_request_conditioner
//
// Conditions two raw, bouncy request lines (set and reset) for a clocked SR
// flip-flop. Each line is synchronised (2 flops), debounced, and every accepted
// rising edge becomes one single-cycle command pulse on s or r. s and r are
// never high together; simultaneous requests are arbitrated by PRIORITY and a
// holdoff gap separates consecutive commands.
//
// Ports:
//   clk        in   clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   set_req_in in   raw set request (asynchronous, may bounce)
//   rst_req_in in   raw reset request (asynchronous, may bounce)
//   s          out  one-cycle set command
//   r          out  one-cycle reset command
//   busy       out  high while the command FSM is not IDLE
//   conflict   out  one-cycle pulse alongside the winner when both were pending
//   cmd_count  out  number of commands issued, wraps 255 -> 0
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles after the synchroniser to accept a level (1..255)
//   HOLDOFF_CYCLES   idle cycles after each command (0..255)
//   PRIORITY         0: reset wins a tie, 1: set wins a tie

module sr_request_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 2,
    parameter int PRIORITY        = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_req_in,
    input  logic       rst_req_in,
    output logic       s,
    output logic       r,
    output logic       busy,
    output logic       conflict,
    output logic [7:0] cmd_count
);

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] HO_LAST = (HOLDOFF_CYCLES > 0) ? 8'(HOLDOFF_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    // Channel index 0 = set, 1 = reset throughout.
    logic [1:0] raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] acc;       // accepted (debounced) level
    logic [1:0] acc_d;     // accepted level one cycle ago, for edge detection
    logic [1:0] rise;
    logic [1:0] pend;
    logic [1:0] pend_clr;
    logic [7:0] db_cnt [2];

    state_t     state_q;
    state_t     state_n;
    logic [7:0] hold_q;
    logic [7:0] hold_n;
    logic       s_n;
    logic       r_n;
    logic       conflict_n;
    logic       issue;
    logic       pick_set;

    assign raw  = {rst_req_in, set_req_in};
    assign rise = acc & ~acc_d;
    assign busy = (state_q != IDLE);

    // Synchroniser, debounce, edge detection and pending flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 2'b00;
            sync2  <= 2'b00;
            acc    <= 2'b00;
            acc_d  <= 2'b00;
            pend   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= 8'd0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            acc_d <= acc;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == acc[i]) begin
                    // Any return to the accepted level discards the partial count.
                    db_cnt[i] <= 8'd0;
                end else if (db_cnt[i] == DB_LAST) begin
                    acc[i]    <= sync2[i];
                    db_cnt[i] <= 8'd0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 8'd1;
                end
            end
            // A new rise on an already-pending channel merges into the same flag.
            pend <= (pend & ~pend_clr) | rise;
        end
    end

    // FSM state register and registered command outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_q    <= 8'd0;
            s         <= 1'b0;
            r         <= 1'b0;
            conflict  <= 1'b0;
            cmd_count <= 8'd0;
        end else begin
            state_q  <= state_n;
            hold_q   <= hold_n;
            s        <= s_n;
            r        <= r_n;
            conflict <= conflict_n;
            if (issue) begin
                cmd_count <= cmd_count + 8'd1;
            end
        end
    end

    // Next-state and output decode. Only one of s_n/r_n can ever be set, which
    // is what keeps 2'b11 away from the flip-flop.
    always_comb begin
        state_n    = state_q;
        hold_n     = hold_q;
        s_n        = 1'b0;
        r_n        = 1'b0;
        conflict_n = 1'b0;
        pend_clr   = 2'b00;
        issue      = 1'b0;
        pick_set   = pend[0] && (!pend[1] || (PRIORITY != 0));

        case (state_q)
            IDLE: begin
                if (pend != 2'b00) begin
                    issue      = 1'b1;
                    state_n    = ISSUE;
                    s_n        = pick_set;
                    r_n        = !pick_set;
                    pend_clr   = pick_set ? 2'b01 : 2'b10;
                    conflict_n = &pend;
                end
            end
            ISSUE: begin
                hold_n  = 8'd0;
                state_n = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
            end
            HOLDOFF: begin
                if (hold_q == HO_LAST) begin
                    state_n = IDLE;
                end else begin
                    hold_n = hold_q + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sr_request_conditioner.sv
// Testbench for sr_request_conditioner (default parameters, reset wins ties).
// Inputs change on the falling edge; outputs are observed on the falling edge.
// Expected command pulses ({s, r, conflict, cycle}) are queued when stimulus
// is driven and popped by the monitor whenever the DUT emits a pulse.

module tb_sr_request_conditioner;

    logic       clk;
    logic       rst;
    logic       set_req_in;
    logic       rst_req_in;
    logic       s;
    logic       r;
    logic       busy;
    logic       conflict;
    logic [7:0] cmd_count;

    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          exp_count = 0;
    bit          mon_en    = 0;
    logic        q_model;
    logic [34:0] exp_q[$];

    sr_request_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .HOLDOFF_CYCLES (2),
        .PRIORITY       (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .set_req_in(set_req_in),
        .rst_req_in(rst_req_in),
        .s         (s),
        .r         (r),
        .busy      (busy),
        .conflict  (conflict),
        .cmd_count (cmd_count)
    );

    // ---------------- clock / reset block ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SR flip-flop fed by the conditioner's commands.
    always @(posedge clk) begin
        if (rst) q_model <= 1'b0;
        else if (s) q_model <= 1'b1;
        else if (r) q_model <= 1'b0;
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [34:0] exp_v;
        logic [34:0] act_v;
        if (mon_en) begin
            checks++;
            if (s === 1'b1 && r === 1'b1) begin
                failures++;
                $display("FAIL sr_exclusive cyc=%0d s=%b r=%b required not both 1", cyc, s, r);
            end
            if (s === 1'b1 || r === 1'b1 || conflict === 1'b1) begin
                checks++;
                act_v = {s, r, conflict, 32'(cyc)};
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse cyc=%0d s=%b r=%b conflict=%b required no pulse",
                             cyc, s, r, conflict);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (act_v !== exp_v) begin
                        failures++;
                        $display("FAIL pulse got s=%b r=%b conflict=%b cyc=%0d required s=%b r=%b conflict=%b cyc=%0d",
                                 act_v[34], act_v[33], act_v[32], act_v[31:0],
                                 exp_v[34], exp_v[33], exp_v[32], exp_v[31:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_pulse(input logic ps, input logic pr, input logic pc, input int at);
        exp_q.push_back({ps, pr, pc, 32'(at)});
        exp_count++;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        set_req_in = 1'b0;
        rst_req_in = 1'b0;
        tick(3);
        checks += 5;
        if (s !== 1'b0)          begin failures++; $display("FAIL reset_s got %b required 0", s); end
        if (r !== 1'b0)          begin failures++; $display("FAIL reset_r got %b required 0", r); end
        if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got %b required 0", busy); end
        if (conflict !== 1'b0)   begin failures++; $display("FAIL reset_conflict got %b required 0", conflict); end
        if (cmd_count !== 8'd0)  begin failures++; $display("FAIL reset_cmd_count got %0d required 0", cmd_count); end
        rst    = 1'b0;
        mon_en = 1'b1;
        tick(2);
    endtask

    task automatic test_clean_set();
        int   n0;
        logic exp_b;
        set_req_in = 1'b1;
        n0 = cyc + 1;
        push_pulse(1'b1, 1'b0, 1'b0, n0 + 7);
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            exp_b = (cyc >= n0 + 7) && (cyc <= n0 + 9);
            checks++;
            if (busy !== exp_b) begin
                failures++;
                $display("FAIL clean_busy cyc=%0d got %b required %b", cyc, busy, exp_b);
            end
        end
        tick(8);
        set_req_in = 1'b0;
        tick(12);
        checks += 2;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL clean_missing_pulse got %0d outstanding required 0", exp_q.size());
            exp_q.delete();
        end
        if (cmd_count !== 8'(exp_count)) begin
            failures++;
            $display("FAIL clean_cmd_count got %0d required %0d", cmd_count, exp_count[7:0]);
        end
    endtask

    task automatic test_bounce();
        int n0;
        for (int k = 0; k < 6; k++) begin
            set_req_in = (k % 2 == 0);
            tick(1);
        end
        set_req_in = 1'b0;
        tick(12);
        checks++;
        if (cmd_count !== 8'(exp_count)) begin
            failures++;
            $display("FAIL bounce_reject_count got %0d required %0d", cmd_count, exp_count[7:0]);
        end
        for (int k = 0; k < 6; k++) begin
            set_req_in = (k % 2 == 0);
            tick(1);
        end
        set_req_in = 1'b1;
        n0 = cyc + 1;
        push_pulse(1'b1, 1'b0, 1'b0, n0 + 7);
        tick(20);
        set_req_in = 1'b0;
        tick(12);
        checks += 2;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL bounce_missing_pulse got %0d outstanding required 0", exp_q.size());
            exp_q.delete();
        end
        if (cmd_count !== 8'(exp_count)) begin
            failures++;
            $display("FAIL bounce_cmd_count got %0d required %0d", cmd_count, exp_count[7:0]);
        end
    endtask

    task automatic test_simultaneous();
        int n0;
        set_req_in = 1'b1;
        rst_req_in = 1'b1;
        n0 = cyc + 1;
        push_pulse(1'b0, 1'b1, 1'b1, n0 + 7);   // reset wins, conflict flagged
        push_pulse(1'b1, 1'b0, 1'b0, n0 + 11);  // loser after holdoff and IDLE re-entry
        tick(20);
        set_req_in = 1'b0;
        rst_req_in = 1'b0;
        tick(12);
        checks += 2;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL simul_missing_pulse got %0d outstanding required 0", exp_q.size());
            exp_q.delete();
        end
        if (cmd_count !== 8'(exp_count)) begin
            failures++;
            $display("FAIL simul_cmd_count got %0d required %0d", cmd_count, exp_count[7:0]);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        // Reset request accepted while the set command is in holdoff.
        set_req_in = 1'b1;
        n0 = cyc + 1;
        push_pulse(1'b1, 1'b0, 1'b0, n0 + 7);
        tick(2);
        rst_req_in = 1'b1;
        push_pulse(1'b0, 1'b1, 1'b0, n0 + 11);
        tick(18);
        set_req_in = 1'b0;
        rst_req_in = 1'b0;
        tick(12);
        // Three raw rising edges on the reset line yield a single command.
        set_req_in = 1'b1;
        n0 = cyc + 1;
        push_pulse(1'b1, 1'b0, 1'b0, n0 + 7);
        tick(4);
        for (int k = 0; k < 4; k++) begin
            rst_req_in = (k % 2 == 0);
            tick(1);
        end
        rst_req_in = 1'b1;
        push_pulse(1'b0, 1'b1, 1'b0, n0 + 15);
        tick(20);
        set_req_in = 1'b0;
        rst_req_in = 1'b0;
        tick(12);
        checks += 2;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_missing_pulse got %0d outstanding required 0", exp_q.size());
            exp_q.delete();
        end
        if (cmd_count !== 8'(exp_count)) begin
            failures++;
            $display("FAIL b2b_cmd_count got %0d required %0d", cmd_count, exp_count[7:0]);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        set_req_in = 1'b1;
        rst_req_in = 1'b1;
        n0 = cyc + 1;
        push_pulse(1'b0, 1'b1, 1'b1, n0 + 7);
        tick(8);                  // now inside the ISSUE cycle, set still pending
        rst        = 1'b1;
        set_req_in = 1'b0;
        rst_req_in = 1'b0;
        tick(1);
        exp_count = 0;
        checks += 5;
        if (s !== 1'b0)         begin failures++; $display("FAIL midrst_s got %b required 0", s); end
        if (r !== 1'b0)         begin failures++; $display("FAIL midrst_r got %b required 0", r); end
        if (busy !== 1'b0)      begin failures++; $display("FAIL midrst_busy got %b required 0", busy); end
        if (conflict !== 1'b0)  begin failures++; $display("FAIL midrst_conflict got %b required 0", conflict); end
        if (cmd_count !== 8'd0) begin failures++; $display("FAIL midrst_cmd_count got %0d required 0", cmd_count); end
        rst = 1'b0;
        tick(20);
        checks += 3;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL midrst_missing_pulse got %0d outstanding required 0", exp_q.size());
            exp_q.delete();
        end
        if (cmd_count !== 8'(exp_count)) begin
            failures++;
            $display("FAIL midrst_after_count got %0d required %0d", cmd_count, exp_count[7:0]);
        end
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_after_busy got %b required 0", busy);
        end
    endtask

    task automatic test_counter_wrap();
        int n0;
        for (int i = 0; i < 256; i++) begin
            set_req_in = (i % 2 == 0);
            rst_req_in = (i % 2 == 1);
            n0 = cyc + 1;
            push_pulse(i % 2 == 0, i % 2 == 1, 1'b0, n0 + 7);
            tick(8);
        end
        tick(4);
        set_req_in = 1'b0;
        rst_req_in = 1'b0;
        tick(12);
        checks += 3;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL wrap_missing_pulse got %0d outstanding required 0", exp_q.size());
            exp_q.delete();
        end
        if (cmd_count !== 8'(exp_count)) begin
            failures++;
            $display("FAIL wrap_cmd_count got %0d required %0d", cmd_count, exp_count[7:0]);
        end
        if (q_model !== 1'b0) begin
            failures++;
            $display("FAIL wrap_sr_q got %b required 0", q_model);
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        rst        = 1'b1;
        set_req_in = 1'b0;
        rst_req_in = 1'b0;
        test_reset();
        test_clean_set();
        test_bounce();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sr_request_conditioner.md
Name: sr_request_conditioner

Overview:
Upstream conditioning stage for the clocked SR flip-flop. It takes raw, bouncy set/reset request lines and synchronises and debounces each one. It converts each accepted rising edge into a single-cycle s or r command pulse. It guarantees that s and r are never high together, so the invalid 2'b11 code never reaches the flip-flop. Simultaneous requests are arbitrated by a fixed priority, and a minimum idle gap is enforced between issued commands.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles (after synchroniser) required to accept a level change; legal range 1..255
HOLDOFF_CYCLES, 2, idle cycles enforced after each issued pulse before the next may issue; legal range 0..255
PRIORITY, 0, arbitration when both requests are pending: 0 = reset wins, 1 = set wins

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  synchronous, active-high reset
set_req_in  input  1  raw set request (bouncy, not assumed synchronous)
rst_req_in  input  1  raw reset request (bouncy, not assumed synchronous)
s  output  1  one-cycle set command to SR flip-flop
r  output  1  one-cycle reset command to SR flip-flop
busy  output  1  high while FSM not in IDLE
conflict  output  1  one-cycle pulse when both requests pending at an arbitration decision
cmd_count  output  8  number of pulses issued on s or r, wraps 255->0

Behaviour:
- Reset is sampled on posedge clk when rst=1. Cleared state: s=0, r=0, busy=0, conflict=0, cmd_count=0, both synchroniser stages 0, debounce counters 0, accepted levels 0, pending flags 0, FSM=IDLE. Reset applies in every state, including mid-ISSUE or mid-HOLDOFF: outputs are 0 after that edge and pending requests are discarded.
- Synchroniser: each raw input passes through a 2-flop chain; sync2 is the debounced source.
- Debounce, per channel:
  - If sync2 equals the accepted level, the counter is 0.
  - Otherwise the counter increments each cycle.
  - On the edge where the counter would reach DEBOUNCE_CYCLES, the accepted level takes sync2 and the counter clears.
  - Any return of sync2 to the accepted level before then clears the counter; the glitch is ignored.
- Event detection: an accepted-level 0->1 transition sets that channel's pending flag on the next edge. 1->0 transitions produce no event. A new event on an already-pending channel is merged; there is no double issue.
- FSM states: IDLE, ISSUE, HOLDOFF.
  - IDLE, no pending: remain.
  - IDLE, exactly one pending: go to ISSUE, drive that channel's output high for the ISSUE cycle, clear its pending flag.
  - IDLE, both pending: winner chosen per PRIORITY; conflict pulses high for one cycle, coincident with the winner's pulse. The loser stays pending and issues after holdoff.
  - ISSUE: lasts exactly 1 cycle. cmd_count increments by 1 (mod 256). Then go to HOLDOFF, or directly to IDLE if HOLDOFF_CYCLES=0.
  - HOLDOFF: s=r=0 for exactly HOLDOFF_CYCLES cycles, then IDLE. Events arriving during ISSUE/HOLDOFF are recorded as pending.
- Outputs s, r, conflict are registered. Invariant: s&r == 0 in every cycle. The bench asserts this continuously.
- Latency: raw input is first sampled high at edge N and held stable. Then s (or r) is high for the one cycle following edge N+DEBOUNCE_CYCLES+3, provided the FSM is IDLE. With defaults this is edge N+7.
- Minimum spacing between consecutive pulse rising edges: HOLDOFF_CYCLES+2 cycles, counting the return to IDLE and the re-issue.
- busy is high from the edge entering ISSUE through the last HOLDOFF cycle.

Test Plan:
1. Clean set: set_req_in 0->1 at edge 10, held 20 cycles -> s=1 for exactly the cycle after edge 17; r stays 0; cmd_count=1; busy high cycles 17..19.
2. Bounce rejection: set_req_in toggles 1,0,1,0 each cycle for 6 cycles then returns to 0 -> no s pulse, cmd_count=0. The same toggling followed by a stable-high hold -> exactly one s pulse.
3. Simultaneous requests, PRIORITY=0: both raw inputs rise at the same edge -> r pulses first with conflict=1 in the same cycle. s pulses 4 cycles later (HOLDOFF_CYCLES=2 plus IDLE re-entry). s&r never both 1; cmd_count=2.
4. Repeat while busy: second clean rst_req_in edge accepted during HOLDOFF -> issued immediately after return to IDLE. Three rising edges while pending -> one pulse only.
5. Reset mid-operation: assert rst during the ISSUE cycle with the other channel pending -> s=r=0, busy=0, cmd_count=0 after the edge. No pulse is issued after rst deasserts until a new qualified edge.
6. Counter wrap: issue 256 alternating set/reset commands -> cmd_count reads 0. The chained SR flip-flop q follows last command (q=0 after final reset).
